// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control unit: opcodes, instruction
// field positions and sequencer state encodings.
package cpu_pkg;

    localparam int unsigned OPC_MSB = 7;
    localparam int unsigned OPC_LSB = 4;
    localparam int unsigned RD_MSB  = 3;
    localparam int unsigned RD_LSB  = 2;
    localparam int unsigned RS_MSB  = 1;
    localparam int unsigned RS_LSB  = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_FETCH_IMM = 3'd2,
        ST_EXEC      = 3'd3,
        ST_HALT      = 3'd4
    } cu_state_t;

    // Opcodes 1..7 write rd; 1..5 also update Z/C.
    function automatic logic op_writes_reg(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_LDI);
    endfunction

    function automatic logic op_sets_flags(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 8-bit ALU; carry is the 9th bit of add/sub (borrow for SUB).
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] result,
    output logic       carry
);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB:  {carry, result} = {1'b0, a} - {1'b0, b};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_MOV:  result = b;
            OP_LDI:  result = b;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
// Optional imem wait timeout enabled by defining CU_IMEM_TIMEOUT_EN.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pc_in,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_valid,
    input  logic [7:0] imem_data,
    output logic [1:0] read_addr1,
    output logic [1:0] read_addr2,
    input  logic [7:0] read_data1,
    input  logic [7:0] read_data2,
    output logic       pc_write_enable,
    output logic       write_enable,
    output logic [1:0] write_addr,
    output logic [7:0] write_data,
    output logic       flag_z,
    output logic       flag_c,
    output logic       halted,
    output logic       fault
);

    cu_state_t  r_state;
    cu_state_t  w_next;
    logic [7:0] r_ir;
    logic [7:0] r_imm;
    logic [7:0] r_opa;
    logic [7:0] r_opb;
    logic       r_flag_z;
    logic       r_flag_c;
    logic       r_rst_q;

    logic [3:0] w_opcode;
    logic [1:0] w_rd;
    logic [1:0] w_rs;
    logic       w_fetching;
    logic       w_hs;
    logic       w_timeout;
    logic [7:0] w_alu_b;
    logic [7:0] w_alu_res;
    logic       w_alu_c;

    assign w_opcode = r_ir[OPC_MSB:OPC_LSB];
    assign w_rd     = r_ir[RD_MSB:RD_LSB];
    assign w_rs     = r_ir[RS_MSB:RS_LSB];

    // Request is suppressed for one cycle after reset so a response to a
    // request aborted by reset can never be taken as a new handshake.
    assign w_fetching = ((r_state == ST_FETCH) || (r_state == ST_FETCH_IMM)) && !r_rst_q;
    assign w_hs       = w_fetching && imem_valid && !reset;

    assign imem_req   = w_fetching;
    assign imem_addr  = pc_in;
    assign read_addr1 = w_rd;
    assign read_addr2 = w_rs;
    assign flag_z     = r_flag_z;
    assign flag_c     = r_flag_c;
    assign halted     = (r_state == ST_HALT);

    assign w_alu_b = (w_opcode == OP_LDI) ? r_imm : r_opb;

    cpu_alu u_alu (
        .op     (w_opcode),
        .a      (r_opa),
        .b      (w_alu_b),
        .result (w_alu_res),
        .carry  (w_alu_c)
    );

`ifdef CU_IMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_fault;

    assign w_timeout = w_fetching && !imem_valid
                       && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign fault     = r_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_fault    <= 1'b0;
        end else if (w_hs) begin
            r_wait_cnt <= '0;
        end else if (w_timeout) begin
            r_wait_cnt <= '0;
            r_fault    <= 1'b1;
        end else if (w_fetching && !imem_valid) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign fault     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        r_rst_q <= reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        pc_write_enable = 1'b0;
        write_enable    = 1'b0;
        write_addr      = '0;
        write_data      = '0;
        case (r_state)
            ST_FETCH: begin
                if (w_hs) begin
                    pc_write_enable = 1'b1;
                    w_next          = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_opcode == OP_LDI) begin
                    w_next = ST_FETCH_IMM;
                end else if (w_opcode == OP_HALT) begin
                    w_next = ST_HALT;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_FETCH_IMM: begin
                if (w_hs) begin
                    pc_write_enable = 1'b1;
                    w_next          = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_writes_reg(w_opcode) && !reset) begin
                    write_enable = 1'b1;
                    write_addr   = w_rd;
                    write_data   = w_alu_res;
                end
                w_next = ST_FETCH;
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase
        if (w_timeout) begin
            w_next = ST_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir     <= '0;
            r_imm    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else begin
            if ((r_state == ST_FETCH) && w_hs) begin
                r_ir <= imem_data;
            end
            if (r_state == ST_DECODE) begin
                r_opa <= read_data1;
                r_opb <= read_data2;
            end
            if ((r_state == ST_FETCH_IMM) && w_hs) begin
                r_imm <= imem_data;
            end
            if ((r_state == ST_EXEC) && op_sets_flags(w_opcode)) begin
                r_flag_z <= (w_alu_res == 8'h00);
                r_flag_c <= w_alu_c;
            end
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit with a behavioural register file and
// instruction memory; honours CU_IMEM_TIMEOUT_EN for the timeout scenario.
module tb_cpu_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pc_in;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid;
    logic [7:0] imem_data;
    logic [1:0] read_addr1;
    logic [1:0] read_addr2;
    logic [7:0] read_data1;
    logic [7:0] read_data2;
    logic       pc_write_enable;
    logic       write_enable;
    logic [1:0] write_addr;
    logic [7:0] write_data;
    logic       flag_z;
    logic       flag_c;
    logic       halted;
    logic       fault;

    always #5 clk = ~clk;

    cpu_control_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_valid      (imem_valid),
        .imem_data       (imem_data),
        .read_addr1      (read_addr1),
        .read_addr2      (read_addr2),
        .read_data1      (read_data1),
        .read_data2      (read_data2),
        .pc_write_enable (pc_write_enable),
        .write_enable    (write_enable),
        .write_addr      (write_addr),
        .write_data      (write_data),
        .flag_z          (flag_z),
        .flag_c          (flag_c),
        .halted          (halted),
        .fault           (fault)
    );

    // Instruction memory: automatic responder with programmable wait, or manual valid.
    logic [7:0]  imem [256];
    logic        mem_manual;
    logic        man_valid;
    int unsigned mem_delay;
    int unsigned wcnt = 0;

    always @(posedge clk) begin
        if (!imem_req || imem_valid) wcnt <= 0;
        else                         wcnt <= wcnt + 1;
    end
    assign imem_valid = mem_manual ? man_valid : (imem_req && (wcnt == mem_delay));
    assign imem_data  = imem[imem_addr];

    // Register file model with pulse bookkeeping.
    logic [7:0] rf [4];
    logic [7:0] rf_pc;
    logic       rf_clr;
    logic [7:0] pc_init;
    int         cyc = 0;
    int         pwe_cnt, we_cnt, both_cnt;
    int         hold_err = 0;
    logic [1:0] wr_a [16];
    logic [7:0] wr_d [16];
    int         wr_t [16];
    int         pw_t [16];
    logic       prev_wait = 1'b0;
    logic [7:0] prev_addr = 8'h00;

    assign pc_in      = rf_pc;
    assign read_data1 = rf[read_addr1];
    assign read_data2 = rf[read_addr2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_clr) begin
            rf_pc    <= pc_init;
            for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
            pwe_cnt  <= 0;
            we_cnt   <= 0;
            both_cnt <= 0;
        end else begin
            if (pc_write_enable) begin
                rf_pc <= rf_pc + 8'h01;
                if (pwe_cnt < 16) pw_t[pwe_cnt] <= cyc;
                pwe_cnt <= pwe_cnt + 1;
            end
            if (write_enable) begin
                rf[write_addr] <= write_data;
                if (we_cnt < 16) begin
                    wr_a[we_cnt] <= write_addr;
                    wr_d[we_cnt] <= write_data;
                    wr_t[we_cnt] <= cyc;
                end
                we_cnt <= we_cnt + 1;
            end
            if (pc_write_enable && write_enable) both_cnt <= both_cnt + 1;
        end
        if (prev_wait && !reset && !halted && (!imem_req || imem_addr != prev_addr))
            hold_err <= hold_err + 1;
        prev_wait <= imem_req && !imem_valid && !reset;
        prev_addr <= imem_addr;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_prog(input logic [7:0] pc0, input int unsigned delay, input logic manual);
        reset      = 1'b1;
        rf_clr     = 1'b1;
        pc_init    = pc0;
        mem_delay  = delay;
        mem_manual = manual;
        man_valid  = 1'b0;
        step(2);
        reset  = 1'b0;
        rf_clr = 1'b0;
    endtask

    task automatic wait_we(input int n, input int budget);
        int k = 0;
        while (we_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (we_cnt < n) check_val("wait_write_timeout", 32'(we_cnt), 32'(n));
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    endtask

    initial begin
        clear_imem();
        // Reset mid-handshake with a late valid after reset drops.
        imem[8'h10] = 8'h6F;
        reset = 1'b1; rf_clr = 1'b1; pc_init = 8'h10;
        mem_manual = 1'b1; man_valid = 1'b0; mem_delay = 0;
        step(2);
        @(negedge clk);
        check_val("reset_outs",
                  {imem_req, pc_write_enable, write_enable, halted, fault, flag_z, flag_c,
                   read_addr1, read_addr2, write_addr, write_data}, 32'h0);
        step(0);
        @(posedge clk); #1;
        rf_clr = 1'b0; reset = 1'b0;
        step(1);
        @(negedge clk);
        check_val("fetch_req_after_reset", {imem_req, imem_addr}, {1'b1, 8'h10});
        @(posedge clk); #1;
        reset = 1'b1;
        step(1);
        @(negedge clk);
        check_val("req_dropped_in_reset", {imem_req, pc_write_enable}, 2'b00);
        @(posedge clk); #1;
        reset = 1'b0; man_valid = 1'b1;
        @(negedge clk);
        check_val("late_valid_ignored", {imem_req, pc_write_enable}, 2'b00);
        @(posedge clk); #1;
        man_valid = 1'b0;
        @(negedge clk);
        check_val("no_capture", {rf_pc, read_addr1, read_addr2, imem_req, imem_addr},
                  {8'h10, 2'b00, 2'b00, 1'b1, 8'h10});

        // LDI R1,F0 / LDI R2,20 / ADD R1,R2 at zero wait and 3-cycle wait.
        for (int d = 0; d <= 3; d += 3) begin
            clear_imem();
            imem[0] = 8'h74; imem[1] = 8'hF0; imem[2] = 8'h78; imem[3] = 8'h20;
            imem[4] = 8'h16; imem[5] = 8'hF0;
            start_prog(8'h00, d, 1'b0);
            wait_we(3, 80);
            check_val($sformatf("ldi1_d%0d", d), {wr_a[0], wr_d[0]}, {2'd1, 8'hF0});
            check_val($sformatf("ldi2_d%0d", d), {wr_a[1], wr_d[1]}, {2'd2, 8'h20});
            check_val($sformatf("add_d%0d", d), {wr_a[2], wr_d[2]}, {2'd1, 8'h10});
            check_val($sformatf("add_flags_zc_d%0d", d), {flag_z, flag_c}, 2'b01);
            check_val($sformatf("pwe_count_d%0d", d), 32'(pwe_cnt), 32'd5);
            check_val($sformatf("ldi_latency_d%0d", d), 32'(wr_t[1] - wr_t[0]), (d == 0) ? 32'd4 : 32'd10);
            check_val($sformatf("add_latency_d%0d", d), 32'(wr_t[2] - wr_t[1]), (d == 0) ? 32'd3 : 32'd6);
        end

        // SUB to zero, MOV keeps flags, SUB with borrow.
        clear_imem();
        imem[0] = 8'h74; imem[1] = 8'h99; imem[2] = 8'h7C; imem[3] = 8'h55;
        imem[4] = 8'h2F; imem[5] = 8'h61; imem[6] = 8'h2D; imem[7] = 8'hF0;
        start_prog(8'h00, 0, 1'b0);
        wait_we(3, 60);
        check_val("sub_zero", {wr_a[2], wr_d[2], flag_z, flag_c}, {2'd3, 8'h00, 1'b1, 1'b0});
        wait_we(4, 20);
        check_val("mov_keeps_flags", {wr_a[3], wr_d[3], flag_z, flag_c}, {2'd0, 8'h99, 1'b1, 1'b0});
        wait_we(5, 20);
        check_val("sub_borrow", {wr_a[4], wr_d[4], flag_z, flag_c}, {2'd3, 8'h67, 1'b0, 1'b1});

        // Undefined opcode then HALT.
        clear_imem();
        imem[0] = 8'h85; imem[1] = 8'hF0;
        start_prog(8'h00, 0, 1'b0);
        begin
            int k = 0;
            while (!halted && k < 40) begin
                @(negedge clk);
                k++;
            end
            check_val("halted_rise", {halted, fault}, 2'b10);
            check_val("halt_counts", {8'(we_cnt), 8'(pwe_cnt)}, {8'd0, 8'd2});
            check_val("undef_latency", 32'(pw_t[1] - pw_t[0]), 32'd3);
            check_val("halt_timing", 32'(cyc - pw_t[1]), 32'd2);
        end
        begin
            int act = 0;
            repeat (20) begin
                @(negedge clk);
                if (imem_req || pc_write_enable || write_enable || !halted) act++;
            end
            check_val("halt_quiet", 32'(act), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        @(negedge clk);
        check_val("restart_after_halt", {imem_req, halted, imem_addr}, {1'b1, 1'b0, 8'h02});

        // Memory that never answers.
        clear_imem();
        start_prog(8'h00, 0, 1'b1);
        begin
            int rq = 0;
            for (int k = 0; k < 100 && !halted; k++) begin
                @(negedge clk);
                if (imem_req) rq++;
            end
`ifdef CU_IMEM_TIMEOUT_EN
            check_val("timeout_fault", {halted, fault, imem_req}, 3'b110);
            check_val("timeout_req_cycles", 32'(rq), 32'd16);
`else
            check_val("no_timeout", {halted, fault, imem_req}, 3'b001);
            check_val("wait_req_cycles", 32'(rq), 32'd99);
`endif
            check_val("timeout_no_pwe", 32'(pwe_cnt), 32'd0);
        end

        check_val("pulse_overlap", 32'(both_cnt), 32'd0);
        check_val("req_addr_hold", 32'(hold_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
